// File: rtl/led_pattern_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : led_pattern_gen                                               |
// | Purpose  : Prescaled step timebase driving BLINK/SHIFT/BOUNCE/BREATHE    |
// |            LED patterns.                                                 |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module led_pattern_gen #(
  parameter int LED_NUM  = 5,
  parameter int PRESCALE = 50000,
  parameter int PWM_BITS = 8
) (
  input  logic               CLOCK_50,
  input  logic               RESET,
  input  logic [1:0]         mode,
  input  logic [15:0]        period,
  output logic [LED_NUM-1:0] LED,
  output logic               step_pulse
);

  typedef enum logic [1:0] {
    M_BLINK   = 2'd0,
    M_SHIFT   = 2'd1,
    M_BOUNCE  = 2'd2,
    M_BREATHE = 2'd3
  } mode_e;

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int POS_W = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;
  localparam logic [PRE_W-1:0]    PRE_MAX  = PRE_W'(PRESCALE - 1);
  localparam logic [POS_W-1:0]    POS_MAX  = POS_W'(LED_NUM - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
  localparam logic [LED_NUM-1:0]  LED_ONE  = LED_NUM'(1);

  mode_e               mode_q, mode_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [15:0]         stp_q, stp_d;
  logic                phase_q, phase_d;
  logic [LED_NUM-1:0]  shift_q, shift_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                down_q, down_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [LED_NUM-1:0]  led_q, led_d;
  logic                step_q, step_d;

  logic                tick_w;
  logic [15:0]         term_w;
  logic [LED_NUM-1:0]  blink0_w;
  logic [LED_NUM-1:0]  rot_w;

  // BLINK phase-0 pattern: odd LEDs lit, even LEDs dark
  for (genvar i = 0; i < LED_NUM; i++) begin : g_blink
    assign blink0_w[i] = (i % 2 == 1);
  end

  if (LED_NUM == 1) begin : g_rot_single
    assign rot_w = shift_q;
  end else begin : g_rot_multi
    assign rot_w = {shift_q[LED_NUM-2:0], shift_q[LED_NUM-1]};
  end

  assign tick_w = (pre_q == PRE_MAX);
  // period 0 is treated as 1, so the terminal count is 0 in both cases
  assign term_w = (period == 16'd0) ? 16'd0 : period - 16'd1;

  always_comb begin
    mode_d  = mode_q;
    pre_d   = pre_q;
    stp_d   = stp_q;
    phase_d = phase_q;
    shift_d = shift_q;
    pos_d   = pos_q;
    down_d  = down_q;
    duty_d  = duty_q;
    pwm_d   = pwm_q + 1'b1;
    step_d  = 1'b0;
    led_d   = led_q;

    if (mode_e'(mode) != mode_q) begin
      mode_d  = mode_e'(mode);
      pre_d   = '0;
      stp_d   = '0;
      phase_d = 1'b0;
      shift_d = LED_ONE;
      pos_d   = '0;
      down_d  = 1'b0;
      duty_d  = '0;
    end else begin
      pre_d = tick_w ? '0 : pre_q + 1'b1;
      if (tick_w) begin
        // >= also catches a period shrunk below the running count
        if (stp_q >= term_w) begin
          stp_d  = '0;
          step_d = 1'b1;
          case (mode_q)
            M_BLINK: phase_d = ~phase_q;
            M_SHIFT: shift_d = rot_w;
            M_BOUNCE: begin
              if (LED_NUM > 1) begin
                if (!down_q) begin
                  if (pos_q == POS_MAX) begin
                    pos_d  = pos_q - 1'b1;
                    down_d = 1'b1;
                  end else begin
                    pos_d = pos_q + 1'b1;
                  end
                end else begin
                  if (pos_q == '0) begin
                    pos_d  = pos_q + 1'b1;
                    down_d = 1'b0;
                  end else begin
                    pos_d = pos_q - 1'b1;
                  end
                end
              end
            end
            default: begin
              if (!down_q) begin
                if (duty_q == DUTY_MAX) begin
                  duty_d = duty_q - 1'b1;
                  down_d = 1'b1;
                end else begin
                  duty_d = duty_q + 1'b1;
                end
              end else begin
                if (duty_q == '0) begin
                  duty_d = duty_q + 1'b1;
                  down_d = 1'b0;
                end else begin
                  duty_d = duty_q - 1'b1;
                end
              end
            end
          endcase
        end else begin
          stp_d = stp_q + 16'd1;
        end
      end
    end

    case (mode_d)
      M_BLINK:  led_d = phase_d ? ~blink0_w : blink0_w;
      M_SHIFT:  led_d = shift_d;
      M_BOUNCE: led_d = LED_ONE << pos_d;
      default:  led_d = {LED_NUM{(pwm_q < duty_d)}};
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      mode_q  <= M_BLINK;
      pre_q   <= '0;
      stp_q   <= '0;
      phase_q <= 1'b0;
      shift_q <= LED_ONE;
      pos_q   <= '0;
      down_q  <= 1'b0;
      duty_q  <= '0;
      pwm_q   <= '0;
      led_q   <= blink0_w;
      step_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      pre_q   <= pre_d;
      stp_q   <= stp_d;
      phase_q <= phase_d;
      shift_q <= shift_d;
      pos_q   <= pos_d;
      down_q  <= down_d;
      duty_q  <= duty_d;
      pwm_q   <= pwm_d;
      led_q   <= led_d;
      step_q  <= step_d;
    end
  end

  assign LED        = led_q;
  assign step_pulse = step_q;

endmodule
`default_nettype wire
